// File: rtl/bp_me_msg_stream_pump.sv
// Splits one BedRock memory message (header + full payload) into narrow stream beats.
// Optional define BP_ME_PUMP_SIZE_CHECK_EN adds a sticky oversize-payload error flag.
module bp_me_msg_stream_pump #(
  parameter int unsigned header_width_p      = 128,
  parameter int unsigned msg_data_width_p    = 512,
  parameter int unsigned stream_data_width_p = 64,
  // msg_type 3 (uc_wr) and msg_type 1 (wr) carry payload on the command side
  parameter logic [15:0] payload_mask_p      = (16'd1 << 3) | (16'd1 << 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [header_width_p-1:0]      msg_header_i,
  input  logic [msg_data_width_p-1:0]    msg_data_i,
  input  logic                           msg_v_i,
  output logic                           msg_ready_and_o,
  output logic [header_width_p-1:0]      stream_header_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  output logic                           stream_v_o,
  output logic                           stream_last_o,
  input  logic                           stream_ready_and_i,
  output logic                           err_o
);

  localparam int unsigned num_beats_lp      = msg_data_width_p / stream_data_width_p;
  localparam int unsigned bytes_per_beat_lp = stream_data_width_p / 8;
  localparam int unsigned cnt_width_lp      = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;

  typedef enum logic {e_ready, e_stream} state_e;

  state_e                                           state_q, state_d;
  logic [header_width_p-1:0]                        header_q, header_d;
  logic [num_beats_lp-1:0][stream_data_width_p-1:0] data_q, data_d;
  logic [cnt_width_lp-1:0]                          cnt_q, cnt_d;
  logic [cnt_width_lp-1:0]                          last_q, last_d;

  logic [3:0]              msg_type;
  logic [2:0]              msg_size;
  logic                    is_payload;
  int unsigned             msg_bytes;
  int unsigned             beats;
  logic [cnt_width_lp-1:0] last_idx;
  logic                    msg_accept;

  // Beat limit of the incoming message, decoded from type and size.
  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (here by straight-line assignment first), otherwise a latch is inferred.
  always_comb begin
    msg_type   = msg_header_i[3:0];
    msg_size   = msg_header_i[6:4];
    is_payload = payload_mask_p[msg_type];
    msg_bytes  = 32'd1 << msg_size;
    beats      = msg_bytes / bytes_per_beat_lp;
    if (!is_payload || beats == 0) beats = 1;
    if (beats > num_beats_lp)      beats = num_beats_lp;
    last_idx   = cnt_width_lp'(beats - 1);
  end

  // State register.
  // NOTE: sequential state is always written with non-blocking (<=) assignments
  // so every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_ready;
    else            state_q <= state_d;
  end

  // Next-state logic: a message arriving on the final-beat handshake keeps us streaming.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_ready:  if (msg_v_i) state_d = e_stream;
      e_stream: if (stream_ready_and_i && stream_last_o && !msg_v_i) state_d = e_ready;
      default:  state_d = e_ready;
    endcase
  end

  // Output logic.
  always_comb begin
    stream_v_o      = (state_q == e_stream);
    stream_last_o   = stream_v_o && (cnt_q == last_q);
    msg_ready_and_o = (state_q == e_ready) || (stream_last_o && stream_ready_and_i);
  end

  assign msg_accept      = msg_v_i && msg_ready_and_o;
  assign stream_header_o = header_q;
  assign stream_data_o   = data_q[cnt_q];

  // Datapath: capture on accept, advance the beat counter on each non-final beat handshake.
  always_comb begin
    header_d = header_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (msg_accept) begin
      header_d = msg_header_i;
      data_d   = is_payload ? msg_data_i : '0;
      cnt_d    = '0;
      last_d   = last_idx;
    end else if (stream_v_o && stream_ready_and_i && !stream_last_o) begin
      cnt_d = cnt_q + cnt_width_lp'(1);
    end
  end

  // NOTE: the wide payload register is reset as well, so stream_data_o is a known
  // zero out of reset rather than whatever the flops power up with.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      header_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      header_q <= header_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

`ifdef BP_ME_PUMP_SIZE_CHECK_EN
  logic err_q, err_d;

  // Sticky: an accepted payload message larger than the payload field.
  assign err_d = err_q || (msg_accept && is_payload && (msg_bytes * 8 > msg_data_width_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
